// File: rtl/vec_packer.sv
//==============================================================================
// Module      : vec_packer
// Description : Scalar-to-vector packing stream transmitter. Collects XW
//               consecutive QW-bit scalars into one XW-lane vector and sends
//               it on a valid/ready vector interface. A staging array plus an
//               output register form a double buffer, so one scalar per cycle
//               is sustained when downstream does not stall. last_i closes a
//               partial vector early; the lanes that were not filled get PAD.
//
// Ports       : clk      - clock, rising edge
//               rstn     - asynchronous active-low reset
//               data_i   - scalar word
//               valid_i  - scalar valid
//               last_i   - final scalar of a burst (qualified by valid_i)
//               ready_o  - scalar accepted when valid_i && ready_o
//               data_o   - packed vector, lane 0 = first scalar
//               valid_o  - vector valid
//               last_o   - vector was closed by last_i (qualified by valid_o)
//               ready_i  - downstream accepts when valid_o && ready_i
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vec_packer #(
    parameter int              QW  = 32,
    parameter int              XW  = 4,
    parameter logic [QW-1:0]   PAD = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [QW-1:0] data_i,
    input  logic          valid_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic [QW-1:0] data_o [XW],
    output logic          valid_o,
    output logic          last_o,
    input  logic          ready_i
);

    localparam int                 C_CNT_W     = $clog2(XW);
    localparam logic [C_CNT_W-1:0] C_LAST_LANE = C_CNT_W'(XW - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

    // Staging buffer
    logic [QW-1:0]      r_stg [XW];
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_stg_full;
    logic               r_stg_last;

    // Output register
    logic [QW-1:0]      r_out [XW];
    logic               r_valid;
    logic               r_last;

    logic w_out_free;
    logic w_accept;
    logic w_xfer;
    logic w_complete;

    // The output register can take a new vector when empty or being drained.
    assign w_out_free = !r_valid || ready_i;
    // Built only from registered state and ready_i, so there is no
    // combinational path from valid_i/data_i/last_i back to ready_o.
    assign ready_o    = !r_stg_full || w_out_free;
    assign w_accept   = valid_i && ready_o;
    assign w_xfer     = r_stg_full && w_out_free;
    assign w_complete = (r_cnt == C_LAST_LANE) || last_i;

    assign data_o  = r_out;
    assign valid_o = r_valid;
    assign last_o  = r_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < XW; i++) begin
                r_stg[i] <= '0;
                r_out[i] <= '0;
            end
            r_cnt      <= '0;
            r_stg_full <= 1'b0;
            r_stg_last <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            // Output side: move a completed staging vector forward, or drain.
            if (w_xfer) begin
                for (int i = 0; i < XW; i++) begin
                    r_out[i] <= r_stg[i];
                end
                r_last     <= r_stg_last;
                r_valid    <= 1'b1;
                r_stg_full <= 1'b0;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            // Input side: a beat accepted in the same cycle as a transfer
            // lands in lane 0 of the just-freed staging array (r_cnt is 0
            // whenever r_stg_full is set). Its stg_full set is placed after
            // the transfer's clear so that the set wins.
            if (w_accept) begin
                for (int i = 0; i < XW; i++) begin
                    if (C_CNT_W'(i) == r_cnt) begin
                        r_stg[i] <= data_i;
                    end else if (w_complete && (C_CNT_W'(i) > r_cnt)) begin
                        r_stg[i] <= PAD;
                    end
                end
                if (w_complete) begin
                    r_stg_full <= 1'b1;
                    r_stg_last <= last_i;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_packer.sv
//==============================================================================
// Module      : tb_vec_packer
// Description : Self-checking bench for vec_packer (QW=32, XW=4). A
//               scoreboard queue receives the expected vector whenever the
//               bench hands a completing scalar to the DUT, and is popped
//               whenever the DUT hands a vector downstream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vec_packer;

    typedef struct packed {
        logic             l;
        logic [3:0][31:0] d;
    } vec_t;

    logic        clk;
    logic        rstn;

    logic [31:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [31:0] data_o [4];
    logic        valid_o;
    logic        last_o;
    logic        ready_i;

    logic [31:0] p_data_i;
    logic        p_valid_i;
    logic        p_last_i;
    logic        p_ready_o;
    logic [31:0] p_data_o [4];
    logic        p_valid_o;
    logic        p_last_o;
    logic        p_ready_i;

    int          errors = 0;
    int          checks = 0;
    logic        rnd_mode = 1'b0;
    logic        last_acc;

    // Scoreboard and input-side reference state
    vec_t             exp_q[$];
    logic [3:0][31:0] m_lanes;
    int               m_cnt;
    logic             m_full;
    logic             prev_stall;
    vec_t             prev_vec;

    vec_packer #(.QW(32), .XW(4), .PAD(32'h0000_0000)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    vec_packer #(.QW(32), .XW(4), .PAD(32'hDEAD_BEEF)) dut_pad (
        .clk     (clk),
        .rstn    (rstn),
        .data_i  (p_data_i),
        .valid_i (p_valid_i),
        .last_i  (p_last_i),
        .ready_o (p_ready_o),
        .data_o  (p_data_o),
        .valid_o (p_valid_o),
        .last_o  (p_last_o),
        .ready_i (p_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic l);
        vec_t v;
        v.d = {d, c, b, a};
        v.l = l;
        return v;
    endfunction

    function automatic vec_t cur_vec();
        vec_t v;
        for (int j = 0; j < 4; j++) v.d[j] = data_o[j];
        v.l = last_o;
        return v;
    endfunction

    function automatic vec_t cur_pad_vec();
        vec_t v;
        for (int j = 0; j < 4; j++) v.d[j] = p_data_o[j];
        v.l = p_last_o;
        return v;
    endfunction

    // Scoreboard sampling point, called at the falling edge of every cycle.
    task automatic sb_sample();
        vec_t cur;
        vec_t e;
        logic exp_rdy;
        logic xfer;
        logic cmpl;
        cur      = cur_vec();
        last_acc = valid_i && ready_o;
        if (!rstn) begin
            exp_q.delete();
            m_cnt      = 0;
            m_full     = 1'b0;
            m_lanes    = '0;
            prev_stall = 1'b0;
            return;
        end
        checks++;
        exp_rdy = !m_full || !valid_o || ready_i;
        if (ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL sb_ready_o: got %b expected %b", ready_o, exp_rdy);
        end
        if (prev_stall) begin
            checks++;
            if (valid_o !== 1'b1 || cur !== prev_vec) begin
                errors++;
                $display("FAIL sb_stall_hold: got valid_o=%b vec=%h expected valid_o=1 vec=%h",
                         valid_o, cur, prev_vec);
            end
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_vector: got %h expected none", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL sb_vector: got %h expected %h", cur, e);
                end
            end
        end
        prev_stall = (valid_o === 1'b1) && (ready_i === 1'b0);
        prev_vec   = cur;
        xfer = m_full && (!valid_o || ready_i);
        cmpl = 1'b0;
        if (last_acc) begin
            m_lanes[m_cnt] = data_i;
            cmpl = (m_cnt == 3) || last_i;
            if (cmpl) begin
                e.d = m_lanes;
                e.l = last_i;
                exp_q.push_back(e);
                m_lanes = '0;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        if (xfer) m_full = 1'b0;
        if (cmpl) m_full = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
        if (rnd_mode) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        last_acc = 1'b0;
        while (!last_acc) begin
            cyc();
            n++;
            if (!last_acc && n > 400) begin
                errors++;
                checks++;
                $display("FAIL send_timeout: got no accept after %0d cycles expected accept", n);
                last_acc = 1'b1;
            end
        end
        // Garbage on data/last while idle must be ignored.
        valid_i = 1'b0;
        data_i  = $urandom;
        last_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || valid_o !== 1'b0) && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d valid_o=%b expected pending=0 valid_o=0",
                     exp_q.size(), valid_o);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        checks++;
        if (valid_o !== 1'b0 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_last: got %b%b expected 00", valid_o, last_o);
        end
        checks++;
        if (cur_vec() !== mk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", cur_vec());
        end
        checks++;
        if (ready_o !== 1'b1 || p_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 11", ready_o, p_ready_o);
        end
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 1'b0);
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready_o: got %b expected 1 after scalar %0d", ready_o, i);
            end
            if (i == 4) begin
                checks++;
                if (valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early_valid: got %b expected 0", valid_o);
                end
            end
            if (i == 5) begin
                checks++;
                if (valid_o !== 1'b1 || cur_vec() !== mk(1, 2, 3, 4, 0)) begin
                    errors++;
                    $display("FAIL stream_vec1: got valid=%b %h expected valid=1 %h",
                             valid_o, cur_vec(), mk(1, 2, 3, 4, 0));
                end
            end
        end
        cyc();
        checks++;
        if (valid_o !== 1'b1 || cur_vec() !== mk(5, 6, 7, 8, 0)) begin
            errors++;
            $display("FAIL stream_vec2: got valid=%b %h expected valid=1 %h",
                     valid_o, cur_vec(), mk(5, 6, 7, 8, 0));
        end
        wait_drain();
    endtask

    task automatic test_last();
        int n;
        ready_i = 1'b1;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        n = 0;
        while (valid_o !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        checks++;
        if (valid_o !== 1'b1 || cur_vec() !== mk(1, 2, 3, 0, 1)) begin
            errors++;
            $display("FAIL last_flush: got valid=%b %h expected valid=1 %h",
                     valid_o, cur_vec(), mk(1, 2, 3, 0, 1));
        end
        for (int i = 10; i <= 13; i++) send(32'(i), 1'b0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || cur_vec() !== mk(1, 2, 3, 4, 0)) begin
            errors++;
            $display("FAIL bp_stall: got ready_o=%b valid=%b %h expected ready_o=0 valid=1 %h",
                     ready_o, valid_o, cur_vec(), mk(1, 2, 3, 4, 0));
        end
        repeat (5) cyc();
        checks++;
        if (ready_o !== 1'b0 || cur_vec() !== mk(1, 2, 3, 4, 0)) begin
            errors++;
            $display("FAIL bp_hold: got ready_o=%b %h expected ready_o=0 %h",
                     ready_o, cur_vec(), mk(1, 2, 3, 4, 0));
        end
        ready_i = 1'b1;
        for (int i = 9; i <= 12; i++) send(32'(i), 1'b0);
        wait_drain();
    endtask

    task automatic test_pad();
        p_ready_i = 1'b1;
        p_valid_i = 1'b1;
        p_data_i  = 32'd7;
        p_last_i  = 1'b1;
        checks++;
        if (p_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL pad_ready: got %b expected 1", p_ready_o);
        end
        cyc();
        p_valid_i = 1'b0;
        p_last_i  = 1'b0;
        cyc();
        checks++;
        if (p_valid_o !== 1'b1 ||
            cur_pad_vec() !== mk(32'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1)) begin
            errors++;
            $display("FAIL pad_vector: got valid=%b %h expected valid=1 %h", p_valid_o,
                     cur_pad_vec(), mk(32'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1));
        end
        cyc();
        checks++;
        if (p_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pad_drain: got %b expected 0", p_valid_o);
        end
    endtask

    task automatic test_random();
        rnd_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            send(32'h1000 + 32'(k), ($urandom_range(0, 7) == 0));
        end
        rnd_mode = 1'b0;
        ready_i  = 1'b1;
        send(32'hFFFF, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int n;
        ready_i = 1'b1;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_partial: got valid=%b ready=%b expected 0 1", valid_o, ready_o);
        end
        cyc();
        cyc();
        rstn = 1'b1;
        ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
        cyc();
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got valid=%b expected 1", valid_o);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || cur_vec() !== mk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_stall: got valid=%b %h expected valid=0 zero", valid_o, cur_vec());
        end
        cyc();
        cyc();
        rstn = 1'b1;
        ready_i = 1'b1;
        for (int i = 9; i <= 12; i++) send(32'(i), 1'b0);
        n = 0;
        while (valid_o !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        checks++;
        if (valid_o !== 1'b1 || cur_vec() !== mk(9, 10, 11, 12, 0)) begin
            errors++;
            $display("FAIL rst_after: got valid=%b %h expected valid=1 %h",
                     valid_o, cur_vec(), mk(9, 10, 11, 12, 0));
        end
        wait_drain();
    endtask

    initial begin
        data_i    = '0;
        valid_i   = 1'b0;
        last_i    = 1'b0;
        ready_i   = 1'b0;
        p_data_i  = '0;
        p_valid_i = 1'b0;
        p_last_i  = 1'b0;
        p_ready_i = 1'b0;
        m_lanes    = '0;
        m_cnt      = 0;
        m_full     = 1'b0;
        prev_stall = 1'b0;
        prev_vec   = '0;
        last_acc   = 1'b0;
        test_reset();
        test_stream();
        test_last();
        test_backpressure();
        test_pad();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
